alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares one alu_core (pipelined Wishbone slave: strobe/cycle/ack/stall) among NREQ requesters.
//  Round-robin grant per Wishbone cycle; routes ack/stall to the owner; broadcasts pl/pr.
//  Sits between the voice/filter engines and alu_core in the synth datapath.
// PARAMETERS
//  NREQ   4  number of requesters (2..8)
//  OCW    3  outstanding-transaction counter width
// PORTS
//  clk            in   1        clock
//  reset          in   1        asynchronous, active-high
//  req_cyc        in   NREQ     per-requester Wishbone cycle
//  req_stb        in   NREQ     per-requester strobe
//  req_op         in   9*NREQ   op, requester i at [9*i+:9]
//  req_al/bl/ar/br in  18*NREQ  operands, requester i at [18*i+:18]
//  req_cl/cr      in   48*NREQ  addends, requester i at [48*i+:48]
//  req_ack        out  NREQ     ack, only owner bit may be set
//  req_stall      out  NREQ     stall, 1 for every non-owner
//  req_pl/req_pr  out  48       alu_pl/alu_pr broadcast; valid when own req_ack bit is 1
//  alu_cycle      out  1        to alu_core
//  alu_strobe     out  1        to alu_core
//  alu_op         out  9        to alu_core
//  alu_al/bl/ar/br out 18       to alu_core
//  alu_cl/cr      out  48       to alu_core
//  alu_ack        in   1        from alu_core
//  alu_stall      in   1        from alu_core
//  alu_pl/alu_pr  in   48       from alu_core
//  arb_err        out  1        sticky: ack with zero outstanding, or counter overflow
// BEHAVIOUR
//  Reset: state IDLE, owner=0, rr_ptr=0, outst=0, arb_err=0; alu_cycle/alu_strobe/req_ack=0, req_stall=all 1.
//  FSM: IDLE -> OWN on any req_cyc; OWN -> IDLE if owner drops req_cyc and outst==0 (after this cycle's ack),
//   else OWN -> DRAIN; DRAIN -> IDLE when outst reaches 0.
//  Grant: in IDLE pick first req_cyc bit at or after rr_ptr (wrapping); owner registered; alu_cycle=1 from next cycle.
//   On leaving OWN, rr_ptr = owner+1 mod NREQ. IDLE lasts >=1 cycle between owners (one bubble).
//  OWN: alu_cycle=1; alu_strobe=req_stb[owner]; req_stall[owner]=alu_stall; req_ack[owner]=alu_ack.
//  DRAIN: alu_cycle=1, alu_strobe=0, acks still routed to owner; new req_cyc from any requester waits.
//  Operand gating: alu_op and all alu_* operands forced to 0 whenever alu_strobe=0 (alu_core ORs its internal
//   Taylor-engine DSP traffic onto these buses; nonzero idle values corrupt SIN/COS/INV results).
//  outst: +1 on alu_strobe&~alu_stall, -1 on alu_ack, unchanged when both occur in the same cycle.
//   Max in flight: 3 (DSP mode, 3-cycle ack); 1 (function mode, ack after calc_done).
//   alu_ack with outst==0: ignored, arb_err<=1. Increment at all-ones: saturate, arb_err<=1.
//  Latency added: 1 cycle grant in IDLE; none on strobe/ack paths (combinational mux on owner).
//  Requester dropping req_stb without req_cyc: no effect. Owner holding req_cyc keeps the ALU indefinitely (no timeout).
//  Reset mid-transaction: all state cleared immediately; in-flight acks lost (alu_core shares the reset).
// STRUCTURE
//  globals.vh: ALU_MODE_DSP, ALU_FUNC_* (existing); add ALU_OP_W=9, ALU_AB_W=18, ALU_C_W=48.
//  Sub-module alu_rr_picker: combinational (req vector, rr_ptr) -> one-hot grant + index.
//  Top: FSM, owner register, outstanding counter, operand mux + gating.
// TESTING
//  req_cyc=0001, 3 DSP strobes back-to-back -> alu_cycle at cycle 1, req_ack[0] on 3 cycles, outst back to 0.
//  req_cyc=1111 held, each drops cyc after 1 op -> grants in order 0,1,2,3, one IDLE bubble between owners.
//  Owner 2 issues ALU_FUNC_SIN -> req_stall[2]=1 while alu_core busy, single req_ack[2] on calc_done; others stall=1.
//  Owner drops req_cyc with 2 DSP acks pending -> DRAIN, both acks to owner, then next requester granted.
//  Force alu_ack in IDLE -> no req_ack bit set, arb_err=1 and stays 1 until reset.
//  Reset asserted during DRAIN with outst=2 -> next cycle IDLE, outst=0, req_stall=1111, alu_cycle=0.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Purpose: shared widths, opcodes and FSM state type for the alu_core arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_arbiter_pkg;

  localparam int ALU_OP_W = 9;   // opcode width
  localparam int ALU_AB_W = 18;  // multiplier operand width
  localparam int ALU_C_W  = 48;  // addend / result width

  // Bit 8 selects DSP (pipelined MAC) mode; low codes select Taylor functions.
  localparam logic [ALU_OP_W-1:0] ALU_MODE_DSP = 9'h100;
  localparam logic [ALU_OP_W-1:0] ALU_FUNC_SIN = 9'h001;
  localparam logic [ALU_OP_W-1:0] ALU_FUNC_COS = 9'h002;
  localparam logic [ALU_OP_W-1:0] ALU_FUNC_INV = 9'h003;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWN   = 2'd1,
    ARB_DRAIN = 2'd2
  } arb_state_e;

  function automatic logic is_dsp_op(input logic [ALU_OP_W-1:0] op);
    return op[8];
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Purpose: pipelined Wishbone-style ALU bus with N lanes (N=NREQ requester side, N=1 core side).
// Latency: n/a (wiring only).
// Backpressure: stall per lane; pl/pr are shared and qualified by the lane's ack.
// Signals: cyc/stb/op/al/bl/ar/br/cl/cr driven by master; ack/stall/pl/pr driven by slave.
interface alu_arbiter_if #(
  parameter int N = 1
);
  import alu_arbiter_pkg::*;

  logic [N-1:0]          cyc;
  logic [N-1:0]          stb;
  logic [N*ALU_OP_W-1:0] op;
  logic [N*ALU_AB_W-1:0] al;
  logic [N*ALU_AB_W-1:0] bl;
  logic [N*ALU_AB_W-1:0] ar;
  logic [N*ALU_AB_W-1:0] br;
  logic [N*ALU_C_W-1:0]  cl;
  logic [N*ALU_C_W-1:0]  cr;
  logic [N-1:0]          ack;
  logic [N-1:0]          stall;
  logic [ALU_C_W-1:0]    pl;
  logic [ALU_C_W-1:0]    pr;

  modport master (
    output cyc, stb, op, al, bl, ar, br, cl, cr,
    input  ack, stall, pl, pr
  );

  modport slave (
    input  cyc, stb, op, al, bl, ar, br, cl, cr,
    output ack, stall, pl, pr
  );

endinterface

// File: rtl/alu_rr_picker.sv
// Purpose: round-robin pick of the first set request bit at or after ptr_i (wrapping).
// Latency: combinational.
// Backpressure: none; gnt_o is all-zero when no request is set.
// Ports: req_i request vector, ptr_i search start, gnt_o one-hot grant, idx_o granted index.
module alu_rr_picker #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [$clog2(NREQ)-1:0] idx_o
);
  localparam int IW = $clog2(NREQ);

  logic [31:0] pos;
  logic        found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = 32'((int'(ptr_i) + k) % NREQ);
      if (!found && req_i[pos[IW-1:0]]) begin
        found              = 1'b1;
        gnt_o[pos[IW-1:0]] = 1'b1;
        idx_o              = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Purpose: shares one alu_core among NREQ requesters, round-robin per Wishbone cycle.
// Latency: 1 cycle grant from IDLE; strobe/ack/stall paths are combinational through the owner mux.
// Backpressure: owner sees alu_core stall; every non-owner (and the owner while draining) sees stall=1.
// Ports: clk, reset (async, active-high), req_bus (requester lanes), alu_bus (to alu_core), arb_err (sticky).
module alu_arbiter #(
  parameter int NREQ = 4,
  parameter int OCW  = 3
) (
  input  logic          clk,
  input  logic          reset,
  alu_arbiter_if.slave  req_bus,
  alu_arbiter_if.master alu_bus,
  output logic          arb_err
);
  import alu_arbiter_pkg::*;

  localparam int IW = $clog2(NREQ);

  arb_state_e     state_q;
  logic [IW-1:0]  owner_q;
  logic [IW-1:0]  rr_ptr_q;
  logic [OCW-1:0] outst_q;
  logic [OCW-1:0] outst_d;
  logic           arb_err_q;
  logic           err_d;
  logic           alu_cycle_q;

  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   owner_nxt;
  logic            owner_cyc;
  logic            strobe;
  logic            accept;
  logic            ack_ok;

  alu_rr_picker #(.NREQ(NREQ)) u_picker (
    .req_i (req_bus.cyc),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  assign owner_cyc = req_bus.cyc[owner_q];
  // Strobes only pass while the owner still holds its cycle; DRAIN never strobes.
  assign strobe    = (state_q == ARB_OWN) && owner_cyc && req_bus.stb[owner_q];
  assign accept    = strobe && !alu_bus.stall[0];
  // An ack with nothing outstanding is spurious: not counted, not routed.
  assign ack_ok    = alu_bus.ack[0] && (outst_q != '0);
  assign owner_nxt = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    outst_d = outst_q;
    err_d   = 1'b0;
    if (alu_bus.ack[0] && (outst_q == '0)) begin
      err_d = 1'b1;
    end
    if (accept && !ack_ok) begin
      if (&outst_q) begin
        err_d = 1'b1;
      end else begin
        outst_d = outst_q + 1'b1;
      end
    end else if (!accept && ack_ok) begin
      outst_d = outst_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      outst_q     <= '0;
      arb_err_q   <= 1'b0;
      alu_cycle_q <= 1'b0;
    end else begin
      outst_q <= outst_d;
      if (err_d) begin
        arb_err_q <= 1'b1;
      end
      case (state_q)
        ARB_IDLE: begin
          if (|pick_gnt) begin
            owner_q     <= pick_idx;
            state_q     <= ARB_OWN;
            alu_cycle_q <= 1'b1;
          end
        end
        ARB_OWN: begin
          if (!owner_cyc) begin
            rr_ptr_q <= owner_nxt;
            // Judge completion on the post-ack count so a final ack this cycle frees the bus.
            if (outst_d == '0) begin
              state_q     <= ARB_IDLE;
              alu_cycle_q <= 1'b0;
            end else begin
              state_q <= ARB_DRAIN;
            end
          end
        end
        ARB_DRAIN: begin
          if (outst_d == '0) begin
            state_q     <= ARB_IDLE;
            alu_cycle_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ARB_IDLE;
          alu_cycle_q <= 1'b0;
        end
      endcase
    end
  end

  // alu_core ORs its own Taylor-engine traffic onto these buses, so they must be zero when idle.
  assign alu_bus.cyc[0] = alu_cycle_q;
  assign alu_bus.stb[0] = strobe;
  assign alu_bus.op     = strobe ? req_bus.op[owner_q*ALU_OP_W +: ALU_OP_W] : '0;
  assign alu_bus.al     = strobe ? req_bus.al[owner_q*ALU_AB_W +: ALU_AB_W] : '0;
  assign alu_bus.bl     = strobe ? req_bus.bl[owner_q*ALU_AB_W +: ALU_AB_W] : '0;
  assign alu_bus.ar     = strobe ? req_bus.ar[owner_q*ALU_AB_W +: ALU_AB_W] : '0;
  assign alu_bus.br     = strobe ? req_bus.br[owner_q*ALU_AB_W +: ALU_AB_W] : '0;
  assign alu_bus.cl     = strobe ? req_bus.cl[owner_q*ALU_C_W +: ALU_C_W] : '0;
  assign alu_bus.cr     = strobe ? req_bus.cr[owner_q*ALU_C_W +: ALU_C_W] : '0;

  always_comb begin
    req_bus.ack = '0;
    if ((state_q != ARB_IDLE) && ack_ok) begin
      req_bus.ack[owner_q] = 1'b1;
    end
  end

  always_comb begin
    req_bus.stall = '1;
    if (state_q == ARB_OWN) begin
      req_bus.stall[owner_q] = alu_bus.stall[0];
    end
  end

  assign req_bus.pl = alu_bus.pl;
  assign req_bus.pr = alu_bus.pr;
  assign arb_err    = arb_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic reset;
  logic arb_err;

  always #5 clk = ~clk;

  alu_arbiter_if #(.N(NREQ)) rq ();
  alu_arbiter_if #(.N(1))    alu ();

  alu_arbiter #(.NREQ(NREQ), .OCW(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .req_bus (rq.slave),
    .alu_bus (alu.master),
    .arb_err (arb_err)
  );

  // ---------------- alu_core model ----------------
  // DSP ops: ack 3 cycles after acceptance, pl=cl+al, pr=cr+ar.
  // Function ops: stall for 5 cycles, then a single ack with the same result formula.
  logic [2:0]  pv;
  logic [47:0] ppl [3];
  logic [47:0] ppr [3];
  logic [2:0]  busy;
  logic        fack;
  logic [47:0] fpl, fpr;
  logic        force_ack;
  wire         acc = alu.stb[0] & ~alu.stall[0];

  assign alu.stall[0] = (busy != 3'd0);
  assign alu.ack[0]   = pv[2] | fack | force_ack;
  assign alu.pl       = fack ? fpl : ppl[2];
  assign alu.pr       = fack ? fpr : ppr[2];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pv   <= '0;
      busy <= '0;
      fack <= 1'b0;
      fpl  <= '0;
      fpr  <= '0;
      for (int i = 0; i < 3; i++) begin
        ppl[i] <= '0;
        ppr[i] <= '0;
      end
    end else begin
      pv     <= {pv[1:0], acc & is_dsp_op(alu.op)};
      ppl[0] <= alu.cl + {30'b0, alu.al};
      ppr[0] <= alu.cr + {30'b0, alu.ar};
      ppl[1] <= ppl[0];
      ppl[2] <= ppl[1];
      ppr[1] <= ppr[0];
      ppr[2] <= ppr[1];
      fack   <= 1'b0;
      if (acc && !is_dsp_op(alu.op)) begin
        busy <= 3'd5;
        fpl  <= alu.cl + {30'b0, alu.al};
        fpr  <= alu.cr + {30'b0, alu.ar};
      end else if (busy != 3'd0) begin
        busy <= busy - 3'd1;
        if (busy == 3'd1) fack <= 1'b1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int          idx;
    logic [47:0] pl;
    logic [47:0] pr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: #1 after each rising edge, pop on every ack and check idle-bus gating.
  always begin
    @(posedge clk);
    #1;
    if (!reset) begin
      if (!alu.stb[0]) begin
        chk("idle_operand_gating",
            64'(|{alu.op, alu.al, alu.bl, alu.ar, alu.br, alu.cl, alu.cr}), 64'd0);
      end
      if (rq.ack != '0) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_ack: got req_ack=%b, expected no ack", rq.ack);
        end else begin
          mon_e = sb.pop_front();
          chk("ack_owner", 64'(rq.ack), 64'(NREQ'(1) << mon_e.idx));
          chk("ack_pl", 64'(rq.pl), 64'(mon_e.pl));
          chk("ack_pr", 64'(rq.pr), 64'(mon_e.pr));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input int r, input logic [8:0] op,
                       input logic [17:0] al, input logic [17:0] ar,
                       input logic [47:0] cl, input logic [47:0] cr,
                       input logic [47:0] epl, input logic [47:0] epr);
    exp_t e;
    rq.stb[r]           = 1'b1;
    rq.op[r*9 +: 9]     = op;
    rq.al[r*18 +: 18]   = al;
    rq.bl[r*18 +: 18]   = 18'h00003;
    rq.ar[r*18 +: 18]   = ar;
    rq.br[r*18 +: 18]   = 18'h00005;
    rq.cl[r*48 +: 48]   = cl;
    rq.cr[r*48 +: 48]   = cr;
    e.idx = r;
    e.pl  = epl;
    e.pr  = epr;
    sb.push_back(e);
  endtask

  task automatic wait_owner(output int g, output int idle);
    g    = -1;
    idle = 0;
    for (int c = 0; c < 30 && g < 0; c++) begin
      @(negedge clk);
      if (alu.cyc[0] == 1'b0) idle++;
      for (int i = 0; i < NREQ; i++) begin
        if (rq.stall[i] == 1'b0 && g < 0) g = i;
      end
    end
    if (g < 0) begin
      tests++;
      fails++;
      $display("FAIL wait_owner: no requester granted within 30 cycles, expected a grant");
    end
  endtask

  task automatic wait_drain(input string name);
    for (int c = 0; c < 40 && sb.size() != 0; c++) @(negedge clk);
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s: %0d acks still pending after 40 cycles, expected 0", name, sb.size());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- directed tests ----------------
  int g, idle;
  logic [17:0] t2_al [4] = '{18'h00001, 18'h00002, 18'h00004, 18'h00008};
  logic [47:0] t2_pl [4] = '{48'h11, 48'h12, 48'h14, 48'h18};

  initial begin
    reset     = 1'b1;
    force_ack = 1'b0;
    rq.cyc = '0; rq.stb = '0; rq.op = '0;
    rq.al = '0; rq.bl = '0; rq.ar = '0; rq.br = '0; rq.cl = '0; rq.cr = '0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_alu_cycle", 64'(alu.cyc), 64'd0);
    chk("rst_alu_strobe", 64'(alu.stb), 64'd0);
    chk("rst_req_ack", 64'(rq.ack), 64'd0);
    chk("rst_req_stall", 64'(rq.stall), 64'hF);
    chk("rst_arb_err", 64'(arb_err), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // T1: single requester, three back-to-back DSP strobes
    rq.cyc = 4'b0001;
    #1 chk("grant_not_yet", 64'(alu.cyc), 64'd0);
    @(negedge clk);
    chk("alu_cycle_cycle1", 64'(alu.cyc), 64'd1);
    chk("owner0_stall", 64'(rq.stall), 64'hE);
    issue(0, ALU_MODE_DSP | 9'h001, 18'h00011, 18'h00022, 48'h100, 48'h200, 48'h111, 48'h222);
    @(negedge clk);
    issue(0, ALU_MODE_DSP | 9'h002, 18'h3FFFF, 18'h00001, 48'h1, 48'hFFFF_FFFF_FFFF, 48'h40000, 48'h0);
    @(negedge clk);
    issue(0, ALU_MODE_DSP | 9'h003, 18'h12345, 18'h0ABCD, 48'h1000_0000_0000, 48'h0,
          48'h1000_0001_2345, 48'h0ABCD);
    @(negedge clk);
    rq.stb = '0;
    wait_drain("t1_drain");
    rq.cyc = '0;
    @(negedge clk);
    chk("t1_release_idle", 64'(alu.cyc), 64'd0);

    // T2: all four hold cyc, each does one op then drops
    do_reset();
    rq.cyc = 4'b1111;
    for (int k = 0; k < NREQ; k++) begin
      wait_owner(g, idle);
      chk("rr_order", 64'(g), 64'(k));
      if (k > 0) chk("rr_bubble", 64'(idle), 64'd1);
      if (g >= 0) begin
        issue(g, ALU_MODE_DSP | 9'(k), t2_al[k], t2_al[k], 48'h10, 48'h0, t2_pl[k], 48'(t2_al[k]));
        @(negedge clk);
        rq.stb[g] = 1'b0;
        wait_drain("t2_drain");
        rq.cyc[g] = 1'b0;
      end
    end

    // T3: owner 2 issues a SIN function op
    @(negedge clk);
    rq.cyc = 4'b0100;
    wait_owner(g, idle);
    chk("sin_owner", 64'(g), 64'd2);
    issue(2, ALU_FUNC_SIN, 18'h00100, 18'h00200, 48'hABC, 48'h0, 48'hBBC, 48'h200);
    @(negedge clk);
    rq.stb[2] = 1'b0;
    chk("sin_busy_stall", 64'(rq.stall), 64'hF);
    wait_drain("t3_drain");
    rq.cyc[2] = 1'b0;
    repeat (3) @(negedge clk);

    // T4: owner 3 drops cyc with two DSP acks pending; requester 0 waits
    rq.cyc = 4'b1001;
    wait_owner(g, idle);
    chk("drain_owner", 64'(g), 64'd3);
    issue(3, ALU_MODE_DSP | 9'h005, 18'h00007, 18'h00009, 48'h1, 48'h2, 48'h8, 48'hB);
    @(negedge clk);
    issue(3, ALU_MODE_DSP | 9'h006, 18'h00020, 18'h00030, 48'h100, 48'h200, 48'h120, 48'h230);
    @(negedge clk);
    rq.stb[3] = 1'b0;
    rq.cyc[3] = 1'b0;
    @(negedge clk);
    chk("drain_alu_cycle", 64'(alu.cyc), 64'd1);
    chk("drain_all_stall", 64'(rq.stall), 64'hF);
    wait_drain("t4_drain");
    wait_owner(g, idle);
    chk("after_drain_owner", 64'(g), 64'd0);
    rq.cyc[0] = 1'b0;

    // T5: spurious ack in IDLE
    repeat (3) @(negedge clk);
    chk("pre_err", 64'(arb_err), 64'd0);
    force_ack = 1'b1;
    #1 chk("idle_ack_not_routed", 64'(rq.ack), 64'd0);
    @(negedge clk);
    force_ack = 1'b0;
    chk("err_set", 64'(arb_err), 64'd1);
    repeat (5) @(negedge clk);
    chk("err_sticky", 64'(arb_err), 64'd1);

    // T6: reset during DRAIN with two outstanding
    do_reset();
    chk("err_cleared", 64'(arb_err), 64'd0);
    rq.cyc = 4'b0001;
    wait_owner(g, idle);
    chk("t6_owner", 64'(g), 64'd0);
    issue(0, ALU_MODE_DSP | 9'h007, 18'h00001, 18'h00001, 48'h1, 48'h1, 48'h2, 48'h2);
    @(negedge clk);
    issue(0, ALU_MODE_DSP | 9'h008, 18'h00002, 18'h00002, 48'h2, 48'h2, 48'h4, 48'h4);
    @(negedge clk);
    rq.stb = '0;
    rq.cyc = '0;
    @(negedge clk);
    chk("t6_in_drain", 64'(alu.cyc), 64'd1);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    chk("t6_rst_cycle", 64'(alu.cyc), 64'd0);
    chk("t6_rst_stall", 64'(rq.stall), 64'hF);
    chk("t6_rst_ack", 64'(rq.ack), 64'd0);
    rq.cyc = 4'b0001;
    wait_owner(g, idle);
    chk("t6_regrant", 64'(g), 64'd0);
    rq.cyc = '0;
    @(negedge clk);
    chk("t6_outst_cleared", 64'(alu.cyc), 64'd0);

    repeat (5) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within 100000 time units");
    $fatal(1, "watchdog");
  end

endmodule
